tomasulo_exe: RTL and testbench

//  Execution unit at the far end of the RS issue interface. Owns the CDB grant
//  for its reservation station (RS), keeps the CDB slot-reservation vector
//  (sch_r), executes issued ops in a fixed LATENCY_N-stage pipeline and

---
 rtl/tomasulo_exe.sv | 101 ++++++++++
 tb/tb_tomasulo_exe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tomasulo_exe.sv
// tomasulo_exe: RS-side execution unit that grants CDB slots, runs a LATENCY_N-stage ALU pipe and broadcasts results; define TOMASULO_EXE_MUL_EN to add OP_MUL
module tomasulo_exe #(
   parameter int LATENCY_N = 2,
   parameter int W = 32,
   parameter int TAG_W = 4,
   parameter int IMM_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 cdb_req,
   output logic                 cdb_gnt,
   input  logic                 ext_rsv,
   input  logic                 flush,
   input  logic                 iss_vld_r,
   input  logic [3:0]           iss_op,
   input  logic [W-1:0]         iss_rdata0,
   input  logic [W-1:0]         iss_rdata1,
   input  logic [IMM_W-1:0]     iss_imm,
   input  logic [TAG_W-1:0]     iss_tag,
   output logic                 iss_busy_r,
   output logic [LATENCY_N+1:0] sch_r,
   output logic                 cdb_vld,
   output logic [TAG_W-1:0]     cdb_tag,
   output logic [W-1:0]         cdb_wdata
);
   localparam int SW = LATENCY_N + 2;
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_MUL  = 4'd6;
   logic                 gnt_q;
   logic                 accept;
   logic [SW-1:0]        sch_shift;
   logic [SW-1:0]        sch_nxt;
   logic [W-1:0]         alu;
   logic [W-1:0]         mul_lo;
   logic [LATENCY_N:1]   st_v;
   logic [TAG_W-1:0]     st_tag [1:LATENCY_N];
   logic [W-1:0]         st_res [1:LATENCY_N];
   assign cdb_gnt   = cdb_req & ~iss_busy_r & ~sch_r[LATENCY_N+1] & ~flush;
   assign accept    = iss_vld_r & gnt_q & ~flush;
   assign sch_shift = sch_r >> 1;
   assign sch_nxt   = sch_shift | (SW'(cdb_gnt) << LATENCY_N) | (SW'(ext_rsv) << (LATENCY_N + 1));
   assign cdb_vld   = st_v[LATENCY_N];
   assign cdb_tag   = st_tag[LATENCY_N];
   assign cdb_wdata = st_res[LATENCY_N];
`ifdef TOMASULO_EXE_MUL_EN
   logic [W-1:0] mul_hi;
   logic [W-1:0] st_hi;
   if (LATENCY_N < 2) begin : g_lat_err
      $error("tomasulo_exe: TOMASULO_EXE_MUL_EN needs LATENCY_N >= 2");
   end
   assign mul_lo = iss_rdata0 * {{(W/2){1'b0}}, iss_rdata1[W/2-1:0]};
   assign mul_hi = (iss_op == OP_MUL) ? (iss_rdata0 * {{(W/2){1'b0}}, iss_rdata1[W-1:W/2]}) << (W/2) : '0;
   // Upper partial product travels beside stage 1 and is folded in at stage 2
   always_ff @(posedge clk)
      st_hi <= mul_hi;
`else
   assign mul_lo = '0;
`endif
   // Stage-1 ALU; unknown opcodes yield zero so the tag still retires
   always_comb
      alu = iss_op == OP_ADD  ? iss_rdata0 + iss_rdata1 :
            iss_op == OP_SUB  ? iss_rdata0 - iss_rdata1 :
            iss_op == OP_AND  ? iss_rdata0 & iss_rdata1 :
            iss_op == OP_OR   ? iss_rdata0 | iss_rdata1 :
            iss_op == OP_XOR  ? iss_rdata0 ^ iss_rdata1 :
            iss_op == OP_ADDI ? iss_rdata0 + {{(W-IMM_W){iss_imm[IMM_W-1]}}, iss_imm} :
            iss_op == OP_MUL  ? mul_lo : '0;
   // Control state: slot reservations, busy, grant history and pipe valids; flush wipes all
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sch_r      <= '0;
         iss_busy_r <= 1'b1;
         gnt_q      <= 1'b0;
         st_v       <= '0;
      end else begin
         iss_busy_r <= flush;
         sch_r      <= flush ? '0 : sch_nxt;
         gnt_q      <= cdb_gnt;
         st_v       <= flush ? '0 : LATENCY_N'({st_v, accept});
      end
   // Datapath flops are unreset; validity is carried only by st_v
   always_ff @(posedge clk) begin
      st_tag[1] <= iss_tag;
      st_res[1] <= alu;
      for (int k = 2; k <= LATENCY_N; k++) begin
         st_tag[k] <= st_tag[k-1];
`ifdef TOMASULO_EXE_MUL_EN
         st_res[k] <= st_res[k-1] + ((k == 2) ? st_hi : '0);
`else
         st_res[k] <= st_res[k-1];
`endif
      end
   end
   a_issue_without_grant: assert property (@(posedge clk) disable iff (!rst_n) !(iss_vld_r && !gnt_q && !flush));
   a_slot_collision: assert property (@(posedge clk) disable iff (!rst_n) !(ext_rsv && sch_shift[LATENCY_N+1]));
endmodule

// File: tb/tb_tomasulo_exe.sv
// tb_tomasulo_exe: scoreboard bench for tomasulo_exe at LATENCY_N=2
module tb_tomasulo_exe;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cdb_req, cdb_gnt, ext_rsv, flush, iss_vld_r, iss_busy_r, cdb_vld;
   logic [3:0]  iss_op, iss_tag, cdb_tag;
   logic [31:0] iss_rdata0, iss_rdata1, cdb_wdata;
   logic [15:0] iss_imm;
   logic [3:0]  sch_r;
   typedef struct packed {logic [3:0] tag; logic [31:0] d;} exp_t;
   exp_t sb[$];
   int tests = 0;
   int fails = 0;

   tomasulo_exe #(.LATENCY_N(2)) dut (
      .clk(clk), .rst_n(rst_n), .cdb_req(cdb_req), .cdb_gnt(cdb_gnt), .ext_rsv(ext_rsv),
      .flush(flush), .iss_vld_r(iss_vld_r), .iss_op(iss_op), .iss_rdata0(iss_rdata0),
      .iss_rdata1(iss_rdata1), .iss_imm(iss_imm), .iss_tag(iss_tag), .iss_busy_r(iss_busy_r),
      .sch_r(sch_r), .cdb_vld(cdb_vld), .cdb_tag(cdb_tag), .cdb_wdata(cdb_wdata)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm);
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return a + {{16{imm[15]}}, imm};
`ifdef TOMASULO_EXE_MUL_EN
         4'd6: return a * b;
`endif
         default: return 32'd0;
      endcase
   endfunction

   // scoreboard: every CDB beat must match the oldest expected result
   always @(negedge clk)
      if (rst_n && cdb_vld) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL cdb_unexpected: got tag=%0d wdata=%h, none expected", cdb_tag, cdb_wdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (cdb_tag !== e.tag || cdb_wdata !== e.d) begin
               fails++;
               $display("FAIL cdb_beat: got tag=%0d wdata=%h, expected tag=%0d wdata=%h", cdb_tag, cdb_wdata, e.tag, e.d);
            end
         end
      end

   task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm, input logic [3:0] tag, input bit push);
      iss_vld_r = 1'b1; iss_op = op; iss_rdata0 = a; iss_rdata1 = b; iss_imm = imm; iss_tag = tag;
      if (push) sb.push_back('{tag: tag, d: model(op, a, b, imm)});
   endtask

   task automatic issue_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm, input logic [3:0] tag, input bit push);
      bit got = 0;
      cdb_req = 1'b1;
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         if (cdb_gnt) got = 1;
         else begin @(posedge clk); #1; end
      end
      tests++;
      if (!got) begin fails++; $display("FAIL grant_timeout: got no grant, expected one within 10 cycles"); end
      @(posedge clk); #1;
      cdb_req = 1'b0;
      drive_op(op, a, b, imm, tag, push);
      @(posedge clk); #1;
      iss_vld_r = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
      #1;
      tests++;
      if (sb.size() != 0) begin fails++; $display("FAIL drain: got %0d results outstanding, expected 0", sb.size()); sb.delete(); end
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cdb_req = 1'b1; ext_rsv = 0; flush = 0; iss_vld_r = 0;
      iss_op = 0; iss_rdata0 = 0; iss_rdata1 = 0; iss_imm = 0; iss_tag = 0;
      #12;
      tests++;
      if (sch_r !== 4'b0 || cdb_vld !== 1'b0 || iss_busy_r !== 1'b1 || cdb_gnt !== 1'b0) begin
         fails++; $display("FAIL reset_state: got sch=%b vld=%b busy=%b gnt=%b, expected 0000 0 1 0", sch_r, cdb_vld, iss_busy_r, cdb_gnt);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (iss_busy_r !== 1'b1 || cdb_gnt !== 1'b0) begin
         fails++; $display("FAIL busy_after_release: got busy=%b gnt=%b, expected 1 0", iss_busy_r, cdb_gnt);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (iss_busy_r !== 1'b0 || cdb_gnt !== 1'b1) begin
         fails++; $display("FAIL first_grant: got busy=%b gnt=%b, expected 0 1", iss_busy_r, cdb_gnt);
      end
      @(posedge clk); #1;
      cdb_req = 1'b0;
      @(negedge clk);
      tests++;
      if (sch_r !== 4'b0100) begin fails++; $display("FAIL sch_after_grant: got %b, expected 0100", sch_r); end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_add();
      cdb_req = 1'b1;
      @(negedge clk);
      tests++;
      if (cdb_gnt !== 1'b1) begin fails++; $display("FAIL add_gnt: got %b, expected 1", cdb_gnt); end
      @(posedge clk); #1;
      cdb_req = 1'b0;
      drive_op(4'd0, 32'd7, 32'd5, 16'd0, 4'd3, 1);
      @(posedge clk); #1;
      iss_vld_r = 1'b0;
      @(negedge clk);
      tests++;
      if (cdb_vld !== 1'b0) begin fails++; $display("FAIL add_early: got vld=%b, expected 0", cdb_vld); end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (cdb_vld !== 1'b1 || sch_r[0] !== 1'b1 || cdb_tag !== 4'd3 || cdb_wdata !== 32'd12) begin
         fails++; $display("FAIL add_beat: got vld=%b sch0=%b tag=%0d wdata=%0d, expected 1 1 3 12", cdb_vld, sch_r[0], cdb_tag, cdb_wdata);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      int beats = 0;
      for (int i = 0; i <= 8; i++) begin
         cdb_req = (i < 8);
         if (i == 0) iss_vld_r = 1'b0;
         else begin
            int j = i - 1;
            case (j % 3)
               0: drive_op(4'd1, 32'd0, 32'd1, 16'd0, 4'(j), 1);
               1: drive_op(4'd4, 32'(j) * 32'h1111, 32'hF0F0_F0F0, 16'd0, 4'(j), 1);
               default: drive_op(4'd5, 32'(j + 10), 32'd0, 16'hFFFF, 4'(j), 1);
            endcase
         end
         @(negedge clk);
         if (i < 8) begin
            tests++;
            if (cdb_gnt !== 1'b1) begin fails++; $display("FAIL b2b_gnt[%0d]: got %b, expected 1", i, cdb_gnt); end
         end
         if (cdb_vld) beats++;
         @(posedge clk); #1;
      end
      iss_vld_r = 1'b0; cdb_req = 1'b0;
      for (int i = 9; i <= 11; i++) begin
         @(negedge clk);
         if (cdb_vld) beats++;
         tests++;
         if (cdb_vld !== (i <= 10)) begin fails++; $display("FAIL b2b_vld[%0d]: got %b, expected %b", i, cdb_vld, i <= 10); end
         @(posedge clk); #1;
      end
      tests++;
      if (beats != 8) begin fails++; $display("FAIL b2b_beats: got %0d, expected 8", beats); end
      drain();
   endtask

   task automatic test_ext_rsv();
      ext_rsv = 1'b1;
      @(posedge clk); #1;
      ext_rsv = 1'b0; cdb_req = 1'b1;
      @(negedge clk);
      tests++;
      if (sch_r[3] !== 1'b1 || cdb_gnt !== 1'b0) begin
         fails++; $display("FAIL ext_block: got sch=%b gnt=%b, expected 1xxx 0", sch_r, cdb_gnt);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (cdb_gnt !== 1'b1 || sch_r !== 4'b0100) begin
         fails++; $display("FAIL ext_next_gnt: got gnt=%b sch=%b, expected 1 0100", cdb_gnt, sch_r);
      end
      @(posedge clk); #1;
      cdb_req = 1'b0;
      drive_op(4'd3, 32'h00F0, 32'h0F00, 16'd0, 4'd5, 1);
      @(posedge clk); #1;
      iss_vld_r = 1'b0;
      drain();
   endtask

   task automatic test_flush();
      cdb_req = 1'b1;
      @(posedge clk); #1;
      drive_op(4'd0, 32'd1, 32'd2, 16'd0, 4'd8, 0);
      @(posedge clk); #1;
      drive_op(4'd0, 32'd3, 32'd4, 16'd0, 4'd9, 0);
      flush = 1'b1; ext_rsv = 1'b1;
      @(negedge clk);
      tests++;
      if (cdb_gnt !== 1'b0) begin fails++; $display("FAIL flush_gnt: got %b, expected 0", cdb_gnt); end
      @(posedge clk); #1;
      flush = 1'b0; ext_rsv = 1'b0; iss_vld_r = 1'b0; cdb_req = 1'b0;
      @(negedge clk);
      tests++;
      if (sch_r !== 4'b0 || iss_busy_r !== 1'b1 || cdb_vld !== 1'b0) begin
         fails++; $display("FAIL flush_state: got sch=%b busy=%b vld=%b, expected 0000 1 0", sch_r, iss_busy_r, cdb_vld);
      end
      @(posedge clk); #1;
      @(negedge clk);
      tests++;
      if (iss_busy_r !== 1'b0) begin fails++; $display("FAIL flush_busy_len: got %b, expected 0", iss_busy_r); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests++;
         if (cdb_vld !== 1'b0) begin fails++; $display("FAIL flush_vld[%0d]: got %b, expected 0", i, cdb_vld); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_ops();
      issue_op(4'd6, 32'h0000_FFFF, 32'h0000_FFFF, 16'd0, 4'd1, 1);
      issue_op(4'd15, 32'd9, 32'd9, 16'd0, 4'd2, 1);
      issue_op(4'd2, 32'hFF00_FF00, 32'h0FF0_0FF0, 16'd0, 4'd4, 1);
      issue_op(4'd5, 32'd100, 32'd0, 16'h8000, 4'd6, 1);
      drain();
   endtask

   task automatic test_reset_mid();
      issue_op(4'd0, 32'd1, 32'd1, 16'd0, 4'd7, 0);
      rst_n = 1'b0;
      #1;
      tests++;
      if (cdb_vld !== 1'b0 || sch_r !== 4'b0) begin
         fails++; $display("FAIL midreset_state: got vld=%b sch=%b, expected 0 0000", cdb_vld, sch_r);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++;
         if (cdb_vld !== 1'b0) begin fails++; $display("FAIL midreset_vld[%0d]: got %b, expected 0", i, cdb_vld); end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_add();
      test_back_to_back();
      test_ext_rsv();
      test_flush();
      test_ops();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
